// File: rtl/io_port_ctrl_fl.sv
// rtl/io_port_ctrl_fl.sv - multi-cycle I/O port controller with request/ack handshake and watchdog
//
// Purpose: accepts IN/OUT strobes from the decoder, runs a one-hot
// request/acknowledge handshake with the selected peripheral port, stalls the
// core while the transfer is pending and aborts transfers that exceed TMOUT
// cycles, raising a sticky timeout flag.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_in, out_en    IN / OUT instruction strobes (req_in has priority)
//   port_addr         port index latched at instruction acceptance
//   acc_data          accumulator value captured into out_data for OUT
//   io_in             last captured input word (0 after an aborted IN)
//   stall             combinational hold request to PC/decoder
//   in_req, in_ack    one-hot read request / per-port read acknowledge
//   in_data           packed per-port input words, port p at [p*NBDATA +: NBDATA]
//   out_wr, out_ack   one-hot write request / per-port write acknowledge
//   out_data          registered write data, stable for the whole OUT transfer
//   timeout, tmo_clr  sticky watchdog flag and its synchronous clear

module io_port_ctrl_fl #(
  parameter  int NBDATA = 32,
  parameter  int NBPORT = 2,
  parameter  int TMOUT  = 255,
  localparam int NPORTS = 2 ** NBPORT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic                     out_en,
  input  logic [NBPORT-1:0]        port_addr,
  input  logic [NBDATA-1:0]        acc_data,
  output logic [NBDATA-1:0]        io_in,
  output logic                     stall,
  output logic [NPORTS-1:0]        in_req,
  input  logic [NPORTS-1:0]        in_ack,
  input  logic [NPORTS*NBDATA-1:0] in_data,
  output logic [NPORTS-1:0]        out_wr,
  input  logic [NPORTS-1:0]        out_ack,
  output logic [NBDATA-1:0]        out_data,
  output logic                     timeout,
  input  logic                     tmo_clr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IN_WAIT  = 2'd1,
    S_OUT_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  // Last count value of a WAIT state; the request is then high for TMOUT cycles.
  localparam logic [15:0] CNT_LAST = 16'(TMOUT - 1);

  state_e              state_q;
  logic [NBPORT-1:0]   sel_q;
  logic [15:0]         cnt_q;
  logic [NBDATA-1:0]   io_in_q;
  logic [NBDATA-1:0]   out_data_q;
  logic [NPORTS-1:0]   in_req_q;
  logic [NPORTS-1:0]   out_wr_q;
  logic                timeout_q;

  logic [NPORTS-1:0]   addr_onehot_d;
  logic                sel_in_ack_d;
  logic                sel_out_ack_d;
  logic                cnt_last_d;
  logic [NBDATA-1:0]   sel_in_data_d;

  assign addr_onehot_d = NPORTS'(1) << port_addr;
  // Only the latched port's ack counts; acks on other ports are ignored.
  assign sel_in_ack_d  = in_ack[sel_q];
  assign sel_out_ack_d = out_ack[sel_q];
  assign cnt_last_d    = (cnt_q == CNT_LAST);
  assign sel_in_data_d = in_data[sel_q*NBDATA +: NBDATA];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      io_in_q    <= '0;
      out_data_q <= '0;
      in_req_q   <= '0;
      out_wr_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // Clear first so that an abort in the same cycle overrides it.
      if (tmo_clr) begin
        timeout_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (req_in) begin
            sel_q    <= port_addr;
            cnt_q    <= '0;
            in_req_q <= addr_onehot_d;
            state_q  <= S_IN_WAIT;
          end else if (out_en) begin
            sel_q      <= port_addr;
            cnt_q      <= '0;
            out_data_q <= acc_data;
            out_wr_q   <= addr_onehot_d;
            state_q    <= S_OUT_WAIT;
          end
        end
        S_IN_WAIT: begin
          // Ack is tested before expiry so an ack on the last cycle wins.
          if (sel_in_ack_d) begin
            io_in_q  <= sel_in_data_d;
            in_req_q <= '0;
            state_q  <= S_DONE;
          end else if (cnt_last_d) begin
            io_in_q   <= '0;
            timeout_q <= 1'b1;
            in_req_q  <= '0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_OUT_WAIT: begin
          if (sel_out_ack_d) begin
            out_wr_q <= '0;
            state_q  <= S_DONE;
          end else if (cnt_last_d) begin
            timeout_q <= 1'b1;
            out_wr_q  <= '0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational so the core is held in the very cycle the instruction appears.
  assign stall = ((state_q == S_IDLE) && (req_in || out_en)) ||
                 (state_q == S_IN_WAIT) || (state_q == S_OUT_WAIT);

  assign io_in    = io_in_q;
  assign in_req   = in_req_q;
  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_io_port_ctrl_fl.sv
// tb/tb_io_port_ctrl_fl.sv - scoreboard testbench for io_port_ctrl_fl

module tb_io_port_ctrl_fl;

  logic        clk;
  logic        rst;

  // Shared data inputs
  logic [31:0]  acc_data;
  logic [127:0] in_data;

  // Instance with TMOUT=8
  logic        req_in, out_en, tmo_clr;
  logic [1:0]  port_addr;
  logic [3:0]  in_ack, out_ack;
  logic [31:0] io_in, out_data;
  logic        stall, timeout;
  logic [3:0]  in_req, out_wr;

  // Instance with TMOUT=4
  logic        req_in4, out_en4, tmo_clr4;
  logic [1:0]  port_addr4;
  logic [3:0]  in_ack4, out_ack4;
  logic [31:0] io_in4, out_data4;
  logic        stall4, timeout4;
  logic [3:0]  in_req4, out_wr4;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  io_port_ctrl_fl #(.NBDATA(32), .NBPORT(2), .TMOUT(8)) dut8 (
    .clk(clk), .rst(rst), .req_in(req_in), .out_en(out_en), .port_addr(port_addr),
    .acc_data(acc_data), .io_in(io_in), .stall(stall), .in_req(in_req),
    .in_ack(in_ack), .in_data(in_data), .out_wr(out_wr), .out_ack(out_ack),
    .out_data(out_data), .timeout(timeout), .tmo_clr(tmo_clr)
  );

  io_port_ctrl_fl #(.NBDATA(32), .NBPORT(2), .TMOUT(4)) dut4 (
    .clk(clk), .rst(rst), .req_in(req_in4), .out_en(out_en4), .port_addr(port_addr4),
    .acc_data(acc_data), .io_in(io_in4), .stall(stall4), .in_req(in_req4),
    .in_ack(in_ack4), .in_data(in_data), .out_wr(out_wr4), .out_ack(out_ack4),
    .out_data(out_data4), .timeout(timeout4), .tmo_clr(tmo_clr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pop_check_io(input string name, input logic [31:0] actual);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, actual);
    end else begin
      exp = exp_q.pop_front();
      if (actual !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, actual, exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({io_in, out_data, in_req, out_wr, timeout, stall} !== 74'd0) begin
      errors++;
      $display("FAIL reset_outputs: io_in=%h out_data=%h in_req=%b out_wr=%b timeout=%b stall=%b expected all 0",
               io_in, out_data, in_req, out_wr, timeout, stall);
    end
    checks++;
    if ({io_in4, out_data4, in_req4, out_wr4, timeout4, stall4} !== 74'd0) begin
      errors++;
      $display("FAIL reset_outputs4: io_in=%h in_req=%b out_wr=%b timeout=%b got nonzero expected 0",
               io_in4, in_req4, out_wr4, timeout4);
    end
    #1 req_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || in_req !== 4'b0000) begin
      errors++;
      $display("FAIL reset_stall_follows: stall=%b in_req=%b expected stall=1 in_req=0000", stall, in_req);
    end
    req_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_in();
    int stall_cnt;
    stall_cnt = 0;
    exp_q.push_back(32'h3F800000);
    @(posedge clk); #1;
    req_in = 1'b1; port_addr = 2'd2; in_data[64 +: 32] = 32'h3F800000;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1 req_in = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if (in_req !== 4'b0100) begin
      errors++;
      $display("FAIL in_req_onehot: got %b expected 0100", in_req);
    end
    @(posedge clk); #1 in_ack = 4'b0100;
    @(negedge clk);
    if (stall) stall_cnt++;
    @(posedge clk); #1 in_ack = 4'b0000;
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if (in_req !== 4'b0000) begin
      errors++;
      $display("FAIL in_req_done: got %b expected 0000", in_req);
    end
    pop_check_io("in_io_in", io_in);
    checks++;
    if (stall_cnt != 3) begin
      errors++;
      $display("FAIL in_stall_cycles: got %0d expected 3", stall_cnt);
    end
  endtask

  task automatic test_out();
    int wr_cnt;
    wr_cnt = 0;
    @(posedge clk); #1;
    out_en = 1'b1; port_addr = 2'd1; acc_data = 32'h40490FDB;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL out_stall_accept: got %b expected 1", stall);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      out_en = 1'b0;
      acc_data = 32'h0;
      out_ack = (k == 6) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (out_wr === 4'b0010) wr_cnt++;
      checks++;
      if (out_data !== 32'h40490FDB || stall !== 1'b1) begin
        errors++;
        $display("FAIL out_stable: cycle %0d out_data=%h stall=%b expected 40490fdb stall=1", k, out_data, stall);
      end
    end
    @(posedge clk); #1 out_ack = 4'b0000;
    @(negedge clk);
    checks++;
    if (wr_cnt != 6) begin
      errors++;
      $display("FAIL out_wr_cycles: got %0d expected 6", wr_cnt);
    end
    checks++;
    if (out_wr !== 4'b0000 || stall !== 1'b0 || out_data !== 32'h40490FDB) begin
      errors++;
      $display("FAIL out_done: out_wr=%b stall=%b out_data=%h expected 0000 0 40490fdb", out_wr, stall, out_data);
    end
  endtask

  task automatic test_timeout();
    int hi;
    bit done;
    hi = 0;
    done = 1'b0;
    exp_q.push_back(32'h0);
    @(posedge clk); #1;
    req_in = 1'b1; port_addr = 2'd0;
    @(posedge clk); #1 req_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_req === 4'b0001) begin
        hi++;
      end else begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL tmo_abort: in_req still %b after 20 cycles, expected abort", in_req);
    end
    checks++;
    if (hi != 8) begin
      errors++;
      $display("FAIL tmo_req_cycles: got %0d expected 8", hi);
    end
    pop_check_io("tmo_io_in", io_in);
    checks++;
    if (timeout !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL tmo_flag: timeout=%b stall=%b expected 1 0", timeout, stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got %b expected 1", timeout);
    end
    @(posedge clk); #1 tmo_clr = 1'b1;
    @(posedge clk); #1 tmo_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got %b expected 0", timeout);
    end
  endtask

  task automatic test_priority();
    exp_q.push_back(32'h12345678);
    @(posedge clk); #1;
    req_in = 1'b1; out_en = 1'b1; port_addr = 2'd0; acc_data = 32'hDEADBEEF;
    in_data[0 +: 32] = 32'h12345678;
    @(posedge clk); #1;
    req_in = 1'b0; out_en = 1'b0;
    @(negedge clk);
    checks++;
    if (in_req !== 4'b0001 || out_wr !== 4'b0000) begin
      errors++;
      $display("FAIL prio_in_only: in_req=%b out_wr=%b expected 0001 0000", in_req, out_wr);
    end
    @(posedge clk); #1 in_ack = 4'b1000;
    @(posedge clk); #1 in_ack = 4'b0001;
    @(negedge clk);
    checks++;
    if (in_req !== 4'b0001 || stall !== 1'b1) begin
      errors++;
      $display("FAIL prio_wrong_ack: in_req=%b stall=%b expected 0001 1", in_req, stall);
    end
    @(posedge clk); #1 in_ack = 4'b0000;
    @(negedge clk);
    pop_check_io("prio_io_in", io_in);
    checks++;
    if (out_wr !== 4'b0000 || out_data !== 32'h40490FDB) begin
      errors++;
      $display("FAIL prio_no_out: out_wr=%b out_data=%h expected 0000 40490fdb", out_wr, out_data);
    end
  endtask

  task automatic test_back_to_back();
    in_data[96 +: 32] = 32'hAAAA5555;
    in_data[32 +: 32] = 32'h0BADF00D;
    exp_q.push_back(32'hAAAA5555);
    exp_q.push_back(32'h0BADF00D);
    @(posedge clk); #1 req_in = 1'b1; port_addr = 2'd3;
    @(posedge clk); #1 req_in = 1'b0; in_ack = 4'b1000;
    @(posedge clk); #1 in_ack = 4'b0000;
    @(negedge clk);
    pop_check_io("b2b_first", io_in);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_stall: got %b expected 0", stall);
    end
    @(posedge clk); #1 req_in = 1'b1; port_addr = 2'd1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_stall: got %b expected 1", stall);
    end
    @(posedge clk); #1 req_in = 1'b0; in_ack = 4'b0010;
    @(negedge clk);
    checks++;
    if (in_req !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_second_req: got %b expected 0010", in_req);
    end
    @(posedge clk); #1 in_ack = 4'b0000;
    @(negedge clk);
    pop_check_io("b2b_second", io_in);
  endtask

  task automatic test_ack_final();
    int hi;
    hi = 0;
    exp_q.push_back(32'hC0DEFEED);
    in_data[32 +: 32] = 32'hC0DEFEED;
    @(posedge clk); #1 req_in4 = 1'b1; port_addr4 = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      req_in4 = 1'b0;
      in_ack4 = (k == 4) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (in_req4 === 4'b0010) hi++;
    end
    @(posedge clk); #1 in_ack4 = 4'b0000;
    @(negedge clk);
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL final_req_cycles: got %0d expected 4", hi);
    end
    pop_check_io("final_io_in", io_in4);
    checks++;
    if (timeout4 !== 1'b0 || in_req4 !== 4'b0000) begin
      errors++;
      $display("FAIL final_no_timeout: timeout=%b in_req=%b expected 0 0000", timeout4, in_req4);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 out_en = 1'b1; port_addr = 2'd2; acc_data = 32'h11223344;
    @(posedge clk); #1 out_en = 1'b0;
    @(negedge clk);
    checks++;
    if (out_wr !== 4'b0100 || out_data !== 32'h11223344) begin
      errors++;
      $display("FAIL rstmid_pre: out_wr=%b out_data=%h expected 0100 11223344", out_wr, out_data);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_wr !== 4'b0000 || stall !== 1'b0 || out_data !== 32'h0 || io_in !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: out_wr=%b stall=%b out_data=%h io_in=%h expected all 0",
               out_wr, stall, out_data, io_in);
    end
    out_en = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || out_wr !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_stall_follows: stall=%b out_wr=%b expected 1 0000", stall, out_wr);
    end
    out_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_req, out_wr, stall, timeout, io_in, out_data} !== 74'd0) begin
      errors++;
      $display("FAIL rstmid_release: in_req=%b out_wr=%b stall=%b timeout=%b io_in=%h out_data=%h expected all 0",
               in_req, out_wr, stall, timeout, io_in, out_data);
    end
    exp_q.push_back(32'h0BADF00D);
    in_data[32 +: 32] = 32'h0BADF00D;
    @(posedge clk); #1 req_in = 1'b1; port_addr = 2'd1;
    @(posedge clk); #1 req_in = 1'b0; in_ack = 4'b0010;
    @(posedge clk); #1 in_ack = 4'b0000;
    @(negedge clk);
    pop_check_io("rstmid_idle_in", io_in);
  endtask

  initial begin
    rst = 1'b0;
    req_in = 1'b0; out_en = 1'b0; tmo_clr = 1'b0; port_addr = 2'd0;
    in_ack = 4'b0; out_ack = 4'b0;
    req_in4 = 1'b0; out_en4 = 1'b0; tmo_clr4 = 1'b0; port_addr4 = 2'd0;
    in_ack4 = 4'b0; out_ack4 = 4'b0;
    acc_data = 32'h0;
    for (int p = 0; p < 4; p++) in_data[p*32 +: 32] = 32'hA0000000 | p;

    test_reset();
    test_in();
    test_out();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_ack_final();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
